// File: rtl/mux_arb_nx1_pkg.sv
// mux_arb_nx1_pkg: shared arbitration-mode constants and a channel-index width helper.
package mux_arb_nx1_pkg;
   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;
   function automatic int ch_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/mux_arb_nx1_fifo_sync.sv
// fifo_sync: single-clock FIFO with drop-on-full push and a one-cycle overflow pulse.
module fifo_sync #(
   parameter int DATA_SIZE  = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_push,
   input  logic [DATA_SIZE-1:0] i_data,
   input  logic                 i_pop,
   output logic [DATA_SIZE-1:0] o_data,
   output logic                 o_full,
   output logic                 o_empty,
   output logic                 o_overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
   logic [AW:0]          r_count;
   logic                 w_push, w_pop;
   assign o_full  = r_count == (AW+1)'(FIFO_DEPTH);
   assign o_empty = r_count == '0;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_pop   = i_pop && !o_empty;
   // a full FIFO still takes a push when it pops in the same cycle
   assign w_push  = i_push && (!o_full || w_pop);
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count    <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
         o_overflow <= i_push && !w_push;
      end
   end
   always_ff @(posedge clk) begin
      if (!reset && w_push) r_mem[r_wr_ptr] <= i_data;
   end
endmodule

// File: rtl/mux_arb_nx1.sv
// mux_arb_nx1: per-channel FIFOs merged by a fixed-priority or round-robin arbiter
// into one registered, ready/valid output word.
module mux_arb_nx1
   import mux_arb_nx1_pkg::*;
#(
   parameter int DATA_SIZE  = 12,
   parameter int NUM_CH     = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int MODE       = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CH*DATA_SIZE-1:0] data_in,
   input  logic [NUM_CH-1:0]           valid_in,
   input  logic                        ready_out,
   output logic [DATA_SIZE-1:0]        data_out_mux,
   output logic                        valid_out,
   output logic [ch_w(NUM_CH)-1:0]     grant,
   output logic [NUM_CH-1:0]           full,
   output logic [NUM_CH-1:0]           empty,
   output logic [NUM_CH-1:0]           overflow
);
   localparam int CH_W = ch_w(NUM_CH);
   logic [DATA_SIZE-1:0] w_fifo_data [NUM_CH];
   logic [NUM_CH-1:0]    w_pop;
   logic [CH_W-1:0]      w_win, w_win_fix, w_win_rr, r_rr_ptr;
   logic                 w_any, w_load, w_rr_found;
   assign w_any  = !(&empty);
   assign w_load = !valid_out || ready_out;
   assign w_win  = (MODE == MODE_RR) ? w_win_rr : w_win_fix;
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_pop[g] = w_load && w_any && (w_win == CH_W'(g));
      fifo_sync #(.DATA_SIZE(DATA_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
         .clk       (clk),
         .reset     (reset),
         .i_push    (valid_in[g]),
         .i_data    (data_in[g*DATA_SIZE +: DATA_SIZE]),
         .i_pop     (w_pop[g]),
         .o_data    (w_fifo_data[g]),
         .o_full    (full[g]),
         .o_empty   (empty[g]),
         .o_overflow(overflow[g])
      );
   end
   // later (higher) indices overwrite earlier ones, so the highest non-empty wins
   always_comb begin
      w_win_fix = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (!empty[i]) w_win_fix = CH_W'(i);
   end
   always_comb begin
      w_win_rr   = '0;
      w_rr_found = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         int j;
         j = int'(r_rr_ptr) + k;
         j = (j >= NUM_CH) ? j - NUM_CH : j;
         if (!w_rr_found && !empty[j]) begin
            w_win_rr   = CH_W'(j);
            w_rr_found = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out_mux <= '0;
         grant        <= '0;
         valid_out    <= 1'b0;
         r_rr_ptr     <= '0;
      end else if (w_load) begin
         valid_out <= w_any;
         if (w_any) begin
            data_out_mux <= w_fifo_data[w_win];
            grant        <= w_win;
            r_rr_ptr     <= (w_win == CH_W'(NUM_CH-1)) ? '0 : w_win + CH_W'(1);
         end
      end
   end
endmodule
